// File: rtl/wave_capture_pkg.sv
// wave_capture_pkg: shared state type for the single-shot waveform capture block
package wave_capture_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} cap_state_t;

endpackage

// File: rtl/wave_capture_ram.sv
// capture_ram: simple dual-port sample buffer, synchronous write, registered read
module capture_ram #(
    parameter int WIDTH = 16,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2**AW];

    // array write; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // read data register, cleared by reset so readback starts at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata <= '0;
        else     rdata <= mem[raddr];
    end

endmodule

// File: rtl/wave_capture.sv
// wave_capture: arms, triggers on a rising level crossing of din1, stores DEPTH sample pairs
module wave_capture
    import wave_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] level,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din1,
    input  logic [DATA_WIDTH-1:0] din2,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done
);

    cap_state_t              state_q, state_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0]   prev_din1_q, prev_din1_d;
    logic                    prev_valid_q, prev_valid_d;
    logic                    we;
    logic [DEPTH_LOG2-1:0]   waddr;
    logic [2*DATA_WIDTH-1:0] rdata;

    // state, write pointer and previous-sample registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            prev_din1_q  <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            prev_din1_q  <= prev_din1_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    // next state, trigger detection and buffer write control; abort overrides everything
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        prev_din1_d  = prev_din1_q;
        prev_valid_d = prev_valid_q;
        we           = 1'b0;
        waddr        = wr_ptr_q;
        case (state_q)
            IDLE, DONE: if (arm) begin
                state_d      = ARMED;
                prev_valid_d = 1'b0;
            end
            ARMED: if (din_valid) begin
                prev_din1_d  = din1;
                prev_valid_d = 1'b1;
                if (prev_valid_q && prev_din1_q < level && din1 >= level) begin
                    state_d  = CAPTURE;
                    we       = 1'b1;
                    waddr    = '0;
                    wr_ptr_d = DEPTH_LOG2'(1);
                end
            end
            CAPTURE: if (din_valid) begin
                we       = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (wr_ptr_q == '1) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d  = IDLE;
            we       = 1'b0;
            wr_ptr_d = '0;
        end
    end

    assign busy      = state_q == ARMED || state_q == CAPTURE;
    assign triggered = state_q == CAPTURE || state_q == DONE;
    assign done      = state_q == DONE;
    assign rd_data1  = rdata[DATA_WIDTH-1:0];
    assign rd_data2  = rdata[2*DATA_WIDTH-1:DATA_WIDTH];

    capture_ram #(
        .WIDTH (2*DATA_WIDTH),
        .AW    (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata ({din2, din1}),
        .raddr (rd_addr),
        .rdata (rdata)
    );

endmodule
